pll_dda_ctrl: RTL

- Synchronous controller for the dynamic delay adjust (DDA) port of the EHXPLLC PLL.
- Accepts signed step requests from fabric logic.
- Encodes each request onto DDAMODE/DDAIZR/DDAILAG/DDAIDEL[2:0], holds the code for a settle period, then waits for the PLL LOCK to be stable again before reporting completion.
- Sits between user/SoC control logic and the PLL instance; the PLL's DELAY_CNTL must be "DYNAMIC".

---
 rtl/pll_dda_ctrl.sv | 249 ++++++++++++++++++++++++
 1 files changed

// File: rtl/pll_dda_ctrl.sv
// -----------------------------------------------------------------------------
// pll_dda_ctrl
//
// Controller for the dynamic delay adjust (DDA) port of an EHXPLLC PLL whose
// DELAY_CNTL attribute is set to "DYNAMIC". Fabric logic requests a signed
// phase step. The controller encodes it onto DDAMODE/DDAIZR/DDAILAG/DDAIDEL,
// holds the new code for SETTLE_CYC cycles, then waits for the PLL LOCK to be
// stable for LOCK_STABLE consecutive cycles before reporting completion.
//
// Ports
//   CLKI        in   controller clock (PLL reference clock domain)
//   RST         in   asynchronous active-high reset
//   REQ_VALID   in   step request valid
//   REQ_STEP    in   [4:0] signed step request, legal range -8..+8
//   REQ_READY   out  controller can accept a request (IDLE only)
//   LOCK        in   PLL LOCK, asynchronous to CLKI
//   DDAMODE     out  to PLL DDAMODE (always 1 once running)
//   DDAIZR      out  to PLL DDAIZR (1 = zero step)
//   DDAILAG     out  to PLL DDAILAG (1 = negative step)
//   DDAIDEL     out  [2:0] to PLL DDAIDEL2..0 (|step| - 1)
//   CUR_STEP    out  [4:0] signed step currently applied
//   BUSY        out  high whenever the FSM is not IDLE
//   DONE        out  one-cycle pulse: request completed, lock regained
//   ERR_RANGE   out  one-cycle pulse: request rejected as out of range
//   ERR_TIMEOUT out  one-cycle pulse: lock not regained in time
//   LOCK_LOST   out  one-cycle pulse: synchronised LOCK fell while IDLE
// -----------------------------------------------------------------------------
module pll_dda_ctrl #(
  parameter int SETTLE_CYC   = 4,
  parameter int LOCK_STABLE  = 8,
  parameter int LOCK_TIMEOUT = 1024
) (
  input  logic       CLKI,
  input  logic       RST,
  input  logic       REQ_VALID,
  input  logic [4:0] REQ_STEP,
  output logic       REQ_READY,
  input  logic       LOCK,
  output logic       DDAMODE,
  output logic       DDAIZR,
  output logic       DDAILAG,
  output logic [2:0] DDAIDEL,
  output logic [4:0] CUR_STEP,
  output logic       BUSY,
  output logic       DONE,
  output logic       ERR_RANGE,
  output logic       ERR_TIMEOUT,
  output logic       LOCK_LOST
);

  localparam int SW  = $clog2(SETTLE_CYC + 1);
  localparam int STW = $clog2(LOCK_STABLE + 1);
  localparam int TW  = $clog2(LOCK_TIMEOUT + 1);

  localparam logic [SW-1:0]  SETTLE_LAST = SW'(SETTLE_CYC - 1);
  localparam logic [SW-1:0]  SETTLE_MAX  = SW'(SETTLE_CYC);
  localparam logic [STW-1:0] STABLE_MAX  = STW'(LOCK_STABLE);
  localparam logic [TW-1:0]  TIMEOUT_MAX = TW'(LOCK_TIMEOUT);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    SETTLE    = 2'd1,
    WAIT_LOCK = 2'd2
  } state_t;

  state_t state_q, state_d;

  // LOCK synchroniser plus one history flop for falling-edge detection.
  logic sync1_q, sync1_d;
  logic lock_s_q, lock_s_d;
  logic lock_prev_q, lock_prev_d;

  logic [SW-1:0]  settle_q, settle_d;
  logic [STW-1:0] stable_q, stable_d;
  logic [TW-1:0]  timeout_q, timeout_d;

  logic       ddamode_q, ddamode_d;
  logic       ddaizr_q, ddaizr_d;
  logic       ddailag_q, ddailag_d;
  logic [2:0] ddaidel_q, ddaidel_d;
  logic [4:0] cur_step_q, cur_step_d;

  logic ready_q, ready_d;
  logic busy_q, busy_d;
  logic done_q, done_d;
  logic err_range_q, err_range_d;
  logic err_timeout_q, err_timeout_d;
  logic lock_lost_q, lock_lost_d;

  // Request decode -----------------------------------------------------------
  logic       accept;
  logic       out_of_range;
  logic [4:0] step_mag;
  logic [2:0] step_idel;

  assign accept = REQ_VALID & ready_q;

  // Illegal codes: +9..+15 are 0_1xxx with a nonzero low field, and
  // -16..-9 are exactly the 1_0xxx codes. -8 (1_1000) and +8 (0_1000) pass.
  assign out_of_range = (~REQ_STEP[4] & REQ_STEP[3] & (|REQ_STEP[2:0])) |
                        (REQ_STEP[4] & ~REQ_STEP[3]);

  assign step_mag  = REQ_STEP[4] ? (~REQ_STEP + 5'd1) : REQ_STEP;
  // |s| = 8 gives low field 000, which wraps to 111 as required.
  assign step_idel = step_mag[2:0] - 3'd1;

  // Next-state / output logic -----------------------------------------------
  always_comb begin
    state_d       = state_q;
    sync1_d       = LOCK;
    lock_s_d      = sync1_q;
    lock_prev_d   = lock_s_q;
    settle_d      = settle_q;
    stable_d      = stable_q;
    timeout_d     = timeout_q;
    ddamode_d     = 1'b1;
    ddaizr_d      = ddaizr_q;
    ddailag_d     = ddailag_q;
    ddaidel_d     = ddaidel_q;
    cur_step_d    = cur_step_q;
    done_d        = 1'b0;
    err_range_d   = 1'b0;
    err_timeout_d = 1'b0;
    lock_lost_d   = 1'b0;

    case (state_q)
      IDLE: begin
        lock_lost_d = lock_prev_q & ~lock_s_q;
        if (accept) begin
          if (out_of_range) begin
            err_range_d = 1'b1;
          end else if (REQ_STEP == cur_step_q) begin
            // Already applied: nothing to reprogram, complete immediately.
            done_d = 1'b1;
          end else begin
            cur_step_d = REQ_STEP;
            settle_d   = '0;
            state_d    = SETTLE;
            if (REQ_STEP == 5'd0) begin
              ddaizr_d  = 1'b1;
              ddailag_d = 1'b0;
              ddaidel_d = 3'd0;
            end else begin
              ddaizr_d  = 1'b0;
              ddailag_d = REQ_STEP[4];
              ddaidel_d = step_idel;
            end
          end
        end
      end

      SETTLE: begin
        if (settle_q != SETTLE_MAX) begin
          settle_d = settle_q + 1'b1;
        end
        if (settle_q >= SETTLE_LAST) begin
          stable_d  = '0;
          timeout_d = '0;
          state_d   = WAIT_LOCK;
        end
      end

      WAIT_LOCK: begin
        // Decisions use the registered counts so that the stable and timeout
        // paths have identical latency from the start of WAIT_LOCK.
        if (lock_s_q) begin
          if (stable_q != STABLE_MAX) begin
            stable_d = stable_q + 1'b1;
          end
        end else begin
          stable_d = '0;
        end
        if (timeout_q != TIMEOUT_MAX) begin
          timeout_d = timeout_q + 1'b1;
        end
        if (stable_q >= STABLE_MAX) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end else if (timeout_q >= TIMEOUT_MAX) begin
          err_timeout_d = 1'b1;
          state_d       = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    ready_d = (state_d == IDLE);
    busy_d  = (state_d != IDLE);
  end

  // State register -----------------------------------------------------------
  always_ff @(posedge CLKI or posedge RST) begin
    if (RST) begin
      state_q       <= IDLE;
      sync1_q       <= 1'b0;
      lock_s_q      <= 1'b0;
      lock_prev_q   <= 1'b0;
      settle_q      <= '0;
      stable_q      <= '0;
      timeout_q     <= '0;
      ddamode_q     <= 1'b1;
      ddaizr_q      <= 1'b1;
      ddailag_q     <= 1'b0;
      ddaidel_q     <= 3'd0;
      cur_step_q    <= 5'd0;
      ready_q       <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      err_range_q   <= 1'b0;
      err_timeout_q <= 1'b0;
      lock_lost_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      sync1_q       <= sync1_d;
      lock_s_q      <= lock_s_d;
      lock_prev_q   <= lock_prev_d;
      settle_q      <= settle_d;
      stable_q      <= stable_d;
      timeout_q     <= timeout_d;
      ddamode_q     <= ddamode_d;
      ddaizr_q      <= ddaizr_d;
      ddailag_q     <= ddailag_d;
      ddaidel_q     <= ddaidel_d;
      cur_step_q    <= cur_step_d;
      ready_q       <= ready_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      err_range_q   <= err_range_d;
      err_timeout_q <= err_timeout_d;
      lock_lost_q   <= lock_lost_d;
    end
  end

  assign REQ_READY   = ready_q;
  assign DDAMODE     = ddamode_q;
  assign DDAIZR      = ddaizr_q;
  assign DDAILAG     = ddailag_q;
  assign DDAIDEL     = ddaidel_q;
  assign CUR_STEP    = cur_step_q;
  assign BUSY        = busy_q;
  assign DONE        = done_q;
  assign ERR_RANGE   = err_range_q;
  assign ERR_TIMEOUT = err_timeout_q;
  assign LOCK_LOST   = lock_lost_q;

endmodule
